// File: rtl/mmu_arb_pkg.sv
// Shared state encodings and requester IDs for the MMU request arbiter.
package mmu_arb_pkg;

  typedef enum logic {REQ_IFU = 1'b0, REQ_LSU = 1'b1} req_id_e;

  // state | meaning: IDLE arbitrate | *_AR address phase | *_R data until rlast
  //       | LSU_W AW+W beats (either order) | LSU_B write response
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IFU_AR = 3'd1;
  localparam logic [2:0] ST_IFU_R  = 3'd2;
  localparam logic [2:0] ST_LSU_AR = 3'd3;
  localparam logic [2:0] ST_LSU_R  = 3'd4;
  localparam logic [2:0] ST_LSU_W  = 3'd5;
  localparam logic [2:0] ST_LSU_B  = 3'd6;

endpackage

// File: rtl/mmu_arb_pick.sv
// Two-way request picker: round-robin on ties, or fixed LSU priority.
import mmu_arb_pkg::*;

module mmu_arb_pick #(
  parameter bit RR_EN = 1'b1
) (
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic rr_last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = ifu_req | lsu_req;
    grant_id    = REQ_IFU;
    if (lsu_req && !ifu_req) begin
      grant_id = REQ_LSU;
    end else if (lsu_req && ifu_req) begin
      grant_id = (RR_EN && rr_last == REQ_LSU) ? REQ_IFU : REQ_LSU;
    end
  end

endmodule

// File: rtl/mmu_req_arbiter.sv
// Shares the MMU upstream port between IFU and LSU, one transaction at a time,
// with satp captured at grant and held until the transaction completes.
import mmu_arb_pkg::*;

module mmu_req_arbiter #(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] csr_satp,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [2:0]        ifu_arsize,
  input  logic [7:0]        ifu_arlen,
  input  logic [1:0]        ifu_arburst,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [31:0]       ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  input  logic [7:0]        lsu_arlen,
  input  logic [1:0]        lsu_arburst,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [31:0]       lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [1:0]        lsu_bresp,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  output logic [ADDR_W-1:0] mmu_araddr,
  output logic [2:0]        mmu_arsize,
  output logic [7:0]        mmu_arlen,
  output logic [1:0]        mmu_arburst,
  output logic [ADDR_W-1:0] mmu_arsatp,
  output logic              mmu_arvalid,
  input  logic              mmu_arready,
  input  logic [31:0]       mmu_rdata,
  input  logic [1:0]        mmu_rresp,
  input  logic              mmu_rlast,
  input  logic              mmu_rvalid,
  output logic              mmu_rready,
  output logic [ADDR_W-1:0] mmu_awaddr,
  output logic [ADDR_W-1:0] mmu_awsatp,
  output logic              mmu_awvalid,
  input  logic              mmu_awready,
  output logic [31:0]       mmu_wdata,
  output logic [3:0]        mmu_wstrb,
  output logic              mmu_wvalid,
  input  logic              mmu_wready,
  input  logic [1:0]        mmu_bresp,
  input  logic              mmu_bvalid,
  output logic              mmu_bready
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] satp_q, satp_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rr_last_q, rr_last_d;
  logic              lsu_wr_req, grant_valid, grant_id;
  logic              ar_ifu, ar_lsu, r_ifu, r_lsu, in_w, in_b;
  logic              aw_hs, w_hs;

  // The MMU needs AW and W together, so a lone AW or W does not request.
  assign lsu_wr_req = lsu_awvalid & lsu_wvalid;

  mmu_arb_pick #(.RR_EN(RR_EN)) u_pick (
    .ifu_req     (ifu_arvalid),
    .lsu_req     (lsu_wr_req | lsu_arvalid),
    .rr_last     (rr_last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign ar_ifu = (state_q == ST_IFU_AR);
  assign ar_lsu = (state_q == ST_LSU_AR);
  assign r_ifu  = (state_q == ST_IFU_R);
  assign r_lsu  = (state_q == ST_LSU_R);
  assign in_w   = (state_q == ST_LSU_W);
  assign in_b   = (state_q == ST_LSU_B);

  assign mmu_arvalid = (ar_ifu & ifu_arvalid) | (ar_lsu & lsu_arvalid);
  assign mmu_araddr  = ar_ifu ? ifu_araddr  : lsu_araddr;
  assign mmu_arsize  = ar_ifu ? ifu_arsize  : lsu_arsize;
  assign mmu_arlen   = ar_ifu ? ifu_arlen   : lsu_arlen;
  assign mmu_arburst = ar_ifu ? ifu_arburst : lsu_arburst;
  assign mmu_arsatp  = satp_q;
  assign mmu_awsatp  = satp_q;
  assign ifu_arready = ar_ifu & mmu_arready;
  assign lsu_arready = ar_lsu & mmu_arready;

  assign ifu_rdata  = mmu_rdata;
  assign ifu_rresp  = mmu_rresp;
  assign ifu_rlast  = mmu_rlast;
  assign ifu_rvalid = r_ifu & mmu_rvalid;
  assign lsu_rdata  = mmu_rdata;
  assign lsu_rresp  = mmu_rresp;
  assign lsu_rlast  = mmu_rlast;
  assign lsu_rvalid = r_lsu & mmu_rvalid;
  assign mmu_rready = (r_ifu & ifu_rready) | (r_lsu & lsu_rready);

  assign mmu_awaddr  = lsu_awaddr;
  assign mmu_awvalid = in_w & lsu_awvalid & ~aw_done_q;
  assign lsu_awready = in_w & mmu_awready & ~aw_done_q;
  assign mmu_wdata   = lsu_wdata;
  assign mmu_wstrb   = lsu_wstrb;
  assign mmu_wvalid  = in_w & lsu_wvalid & ~w_done_q;
  assign lsu_wready  = in_w & mmu_wready & ~w_done_q;
  assign lsu_bresp   = mmu_bresp;
  assign lsu_bvalid  = in_b & mmu_bvalid;
  assign mmu_bready  = in_b & lsu_bready;

  assign aw_hs = mmu_awvalid & mmu_awready;
  assign w_hs  = mmu_wvalid & mmu_wready;

  always_comb begin
    state_d   = state_q;
    satp_d    = satp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          satp_d = csr_satp;
          if (grant_id == REQ_IFU) state_d = ST_IFU_AR;
          else if (lsu_wr_req)     state_d = ST_LSU_W;
          else                     state_d = ST_LSU_AR;
        end
      end
      ST_IFU_AR: if (mmu_arvalid && mmu_arready) state_d = ST_IFU_R;
      ST_LSU_AR: if (mmu_arvalid && mmu_arready) state_d = ST_LSU_R;
      ST_IFU_R: begin
        if (mmu_rvalid && mmu_rready && mmu_rlast) begin
          state_d   = ST_IDLE;
          rr_last_d = REQ_IFU;
        end
      end
      ST_LSU_R: begin
        if (mmu_rvalid && mmu_rready && mmu_rlast) begin
          state_d   = ST_IDLE;
          rr_last_d = REQ_LSU;
        end
      end
      ST_LSU_W: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = ST_LSU_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      ST_LSU_B: begin
        if (mmu_bvalid && mmu_bready) begin
          state_d   = ST_IDLE;
          rr_last_d = REQ_LSU;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rr_last starts at IFU so the LSU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      satp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rr_last_q <= REQ_IFU;
    end else begin
      state_q   <= state_d;
      satp_q    <= satp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rr_last_q <= rr_last_d;
    end
  end

  a_idle_no_valid: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_IDLE) |-> !(mmu_arvalid || mmu_awvalid || mmu_wvalid));

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Directed self-checking bench for mmu_req_arbiter.
module tb_mmu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csr_satp;
  logic [31:0] ifu_araddr;  logic [2:0] ifu_arsize; logic [7:0] ifu_arlen; logic [1:0] ifu_arburst;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp;  logic ifu_rlast, ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic [7:0] lsu_arlen; logic [1:0] lsu_arburst;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp;  logic lsu_rlast, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb;  logic lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
  logic [31:0] mmu_araddr;  logic [2:0] mmu_arsize; logic [7:0] mmu_arlen; logic [1:0] mmu_arburst;
  logic [31:0] mmu_arsatp;  logic mmu_arvalid, mmu_arready;
  logic [31:0] mmu_rdata;   logic [1:0] mmu_rresp;  logic mmu_rlast, mmu_rvalid, mmu_rready;
  logic [31:0] mmu_awaddr, mmu_awsatp; logic mmu_awvalid, mmu_awready;
  logic [31:0] mmu_wdata;   logic [3:0] mmu_wstrb;  logic mmu_wvalid, mmu_wready;
  logic [1:0]  mmu_bresp;   logic mmu_bvalid, mmu_bready;

  int tests_run = 0;
  int tests_failed = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;

  mmu_req_arbiter #(.RR_EN(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .csr_satp(csr_satp),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen), .lsu_arburst(lsu_arburst),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .mmu_araddr(mmu_araddr), .mmu_arsize(mmu_arsize), .mmu_arlen(mmu_arlen), .mmu_arburst(mmu_arburst),
    .mmu_arsatp(mmu_arsatp), .mmu_arvalid(mmu_arvalid), .mmu_arready(mmu_arready),
    .mmu_rdata(mmu_rdata), .mmu_rresp(mmu_rresp), .mmu_rlast(mmu_rlast), .mmu_rvalid(mmu_rvalid), .mmu_rready(mmu_rready),
    .mmu_awaddr(mmu_awaddr), .mmu_awsatp(mmu_awsatp), .mmu_awvalid(mmu_awvalid), .mmu_awready(mmu_awready),
    .mmu_wdata(mmu_wdata), .mmu_wstrb(mmu_wstrb), .mmu_wvalid(mmu_wvalid), .mmu_wready(mmu_wready),
    .mmu_bresp(mmu_bresp), .mmu_bvalid(mmu_bvalid), .mmu_bready(mmu_bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mmu_awvalid && mmu_awready) aw_hs_cnt++;
    if (mmu_wvalid && mmu_wready)   w_hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_ar(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mmu_arvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs one single-beat read through the MMU side; reports who got the grant.
  task automatic run_read(input logic [31:0] rdata, output logic ok, output logic [31:0] addr,
                          output logic owner_lsu, output logic [31:0] got_rdata);
    addr = 32'h0; owner_lsu = 1'b0; got_rdata = 32'h0;
    wait_ar(ok);
    if (!ok) return;
    addr = mmu_araddr;
    owner_lsu = lsu_arready;
    tick();
    if (owner_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    mmu_rvalid = 1'b1; mmu_rlast = 1'b1; mmu_rdata = rdata;
    #1;
    if (owner_lsu && lsu_rvalid) got_rdata = lsu_rdata;
    if (!owner_lsu && ifu_rvalid) got_rdata = ifu_rdata;
    tick();
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (mmu_arvalid !== 1'b0 || mmu_awvalid !== 1'b0 || mmu_wvalid !== 1'b0)
      begin tests_failed++; $display("FAIL reset_mmu_valids got ar=%b aw=%b w=%b want 0", mmu_arvalid, mmu_awvalid, mmu_wvalid); end
    tests_run++;
    if (ifu_arready !== 1'b0 || lsu_arready !== 1'b0 || lsu_awready !== 1'b0 || lsu_wready !== 1'b0)
      begin tests_failed++; $display("FAIL reset_req_readys got ifu_ar=%b lsu_ar=%b aw=%b w=%b want 0", ifu_arready, lsu_arready, lsu_awready, lsu_wready); end
    tests_run++;
    if (mmu_arsatp !== 32'h0)
      begin tests_failed++; $display("FAIL reset_satp got %h want 0", mmu_arsatp); end
    tests_run++;
    if (mmu_rready !== 1'b0 || mmu_bready !== 1'b0 || lsu_bvalid !== 1'b0)
      begin tests_failed++; $display("FAIL reset_r_b got rready=%b bready=%b bvalid=%b want 0", mmu_rready, mmu_bready, lsu_bvalid); end
  endtask

  task automatic test_ifu_read();
    csr_satp = 32'h8008_0123; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0;
    ifu_arvalid = 1'b1; mmu_arready = 1'b0;
    #1;
    tests_run++;
    if (mmu_arvalid !== 1'b0) begin tests_failed++; $display("FAIL ifu_grant_not_comb got %b want 0", mmu_arvalid); end
    tick();
    tests_run++;
    if (mmu_arvalid !== 1'b1 || mmu_araddr !== 32'h8000_0000 || mmu_arsatp !== 32'h8008_0123)
      begin tests_failed++; $display("FAIL ifu_ar got v=%b a=%h s=%h want 1 80000000 80080123", mmu_arvalid, mmu_araddr, mmu_arsatp); end
    mmu_arready = 1'b1;
    #1;
    tests_run++;
    if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0)
      begin tests_failed++; $display("FAIL ifu_arready got ifu=%b lsu=%b want 1 0", ifu_arready, lsu_arready); end
    tick();
    ifu_arvalid = 1'b0; mmu_arready = 1'b0;
    mmu_rvalid = 1'b1; mmu_rdata = 32'hDEAD_BEEF; mmu_rlast = 1'b1;
    #1;
    tests_run++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'hDEAD_BEEF || ifu_rlast !== 1'b1 || mmu_rready !== 1'b1)
      begin tests_failed++; $display("FAIL ifu_r got v=%b d=%h l=%b rr=%b want 1 deadbeef 1 1", ifu_rvalid, ifu_rdata, ifu_rlast, mmu_rready); end
    tests_run++;
    if (lsu_rvalid !== 1'b0) begin tests_failed++; $display("FAIL ifu_r_lsu_gated got %b want 0", lsu_rvalid); end
    tick();
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
    #1;
    tests_run++;
    if (mmu_arvalid !== 1'b0 || ifu_rvalid !== 1'b0)
      begin tests_failed++; $display("FAIL ifu_back_idle got ar=%b rv=%b want 0 0", mmu_arvalid, ifu_rvalid); end
  endtask

  task automatic test_tie();
    logic ok, own; logic [31:0] addr, rd;
    apply_reset();
    mmu_arready = 1'b1;
    ifu_araddr = 32'h0000_1000; lsu_araddr = 32'h0000_2000;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    run_read(32'h0000_00A1, ok, addr, own, rd);
    tests_run++;
    if (!ok || own !== 1'b1 || addr !== 32'h0000_2000 || rd !== 32'h0000_00A1)
      begin tests_failed++; $display("FAIL tie1_lsu_first got ok=%b lsu=%b a=%h d=%h want 1 1 2000 a1", ok, own, addr, rd); end
    lsu_araddr = 32'h0000_2004; lsu_arvalid = 1'b1;
    run_read(32'h0000_00A2, ok, addr, own, rd);
    tests_run++;
    if (!ok || own !== 1'b0 || addr !== 32'h0000_1000 || rd !== 32'h0000_00A2)
      begin tests_failed++; $display("FAIL tie2_ifu_first got ok=%b lsu=%b a=%h d=%h want 1 0 1000 a2", ok, own, addr, rd); end
    run_read(32'h0000_00A3, ok, addr, own, rd);
    tests_run++;
    if (!ok || own !== 1'b1 || addr !== 32'h0000_2004 || rd !== 32'h0000_00A3)
      begin tests_failed++; $display("FAIL tie2_lsu_second got ok=%b lsu=%b a=%h d=%h want 1 1 2004 a3", ok, own, addr, rd); end
  endtask

  task automatic test_write_then_read();
    logic ok, own; logic [31:0] addr, rd;
    mmu_awready = 1'b0; mmu_wready = 1'b0; mmu_arready = 1'b1;
    lsu_awaddr = 32'h8010_0000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'hF;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    lsu_araddr = 32'h0000_3000; lsu_arvalid = 1'b1;
    aw_hs_cnt = 0; w_hs_cnt = 0;
    tick();
    tests_run++;
    if (mmu_awvalid !== 1'b1 || mmu_wvalid !== 1'b1 || mmu_arvalid !== 1'b0)
      begin tests_failed++; $display("FAIL wr_first got aw=%b w=%b ar=%b want 1 1 0", mmu_awvalid, mmu_wvalid, mmu_arvalid); end
    tests_run++;
    if (mmu_awaddr !== 32'h8010_0000 || mmu_wdata !== 32'h1234_5678 || mmu_wstrb !== 4'hF || mmu_awsatp !== 32'h8008_0123)
      begin tests_failed++; $display("FAIL wr_fields got a=%h d=%h s=%h satp=%h", mmu_awaddr, mmu_wdata, mmu_wstrb, mmu_awsatp); end
    mmu_awready = 1'b1;
    #1;
    tests_run++;
    if (lsu_awready !== 1'b1 || lsu_wready !== 1'b0)
      begin tests_failed++; $display("FAIL wr_aw_ready got aw=%b w=%b want 1 0", lsu_awready, lsu_wready); end
    tick();
    mmu_wready = 1'b1;
    #1;
    tests_run++;
    if (mmu_awvalid !== 1'b0 || lsu_awready !== 1'b0 || lsu_wready !== 1'b1)
      begin tests_failed++; $display("FAIL wr_aw_done_gate got awv=%b awr=%b wr=%b want 0 0 1", mmu_awvalid, lsu_awready, lsu_wready); end
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; mmu_awready = 1'b0; mmu_wready = 1'b0;
    mmu_bvalid = 1'b1; mmu_bresp = 2'b10;
    #1;
    tests_run++;
    if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'b10 || mmu_bready !== 1'b1 || mmu_wvalid !== 1'b0)
      begin tests_failed++; $display("FAIL wr_b got bv=%b br=%b bready=%b wv=%b want 1 2 1 0", lsu_bvalid, lsu_bresp, mmu_bready, mmu_wvalid); end
    tests_run++;
    if (aw_hs_cnt != 1 || w_hs_cnt != 1)
      begin tests_failed++; $display("FAIL wr_beats got aw=%0d w=%0d want 1 1", aw_hs_cnt, w_hs_cnt); end
    tick();
    mmu_bvalid = 1'b0;
    run_read(32'h0000_00B2, ok, addr, own, rd);
    tests_run++;
    if (!ok || own !== 1'b1 || addr !== 32'h0000_3000 || rd !== 32'h0000_00B2)
      begin tests_failed++; $display("FAIL wr_then_rd got ok=%b lsu=%b a=%h d=%h want 1 1 3000 b2", ok, own, addr, rd); end
  endtask

  task automatic test_satp_hold();
    logic ok;
    csr_satp = 32'h8008_0123; mmu_arready = 1'b1;
    ifu_araddr = 32'h0000_4000; ifu_arvalid = 1'b1;
    wait_ar(ok);
    tests_run++;
    if (!ok || mmu_arsatp !== 32'h8008_0123)
      begin tests_failed++; $display("FAIL satp_grant got ok=%b s=%h want 1 80080123", ok, mmu_arsatp); end
    tick();
    ifu_arvalid = 1'b0; csr_satp = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (mmu_arsatp !== 32'h8008_0123)
        begin tests_failed++; $display("FAIL satp_hold_%0d got %h want 80080123", i, mmu_arsatp); end
    end
    mmu_rvalid = 1'b1; mmu_rlast = 1'b1; mmu_rdata = 32'h0000_00C1;
    tick();
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
    ifu_araddr = 32'h0000_5000; ifu_arvalid = 1'b1;
    wait_ar(ok);
    tests_run++;
    if (!ok || mmu_arsatp !== 32'h0 || mmu_araddr !== 32'h0000_5000)
      begin tests_failed++; $display("FAIL satp_next got ok=%b s=%h a=%h want 1 0 5000", ok, mmu_arsatp, mmu_araddr); end
    tick();
    ifu_arvalid = 1'b0; mmu_rvalid = 1'b1; mmu_rlast = 1'b1;
    tick();
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
  endtask

  task automatic test_burst();
    logic ok, own; logic [31:0] addr, rd;
    int beats, fwd, leak;
    mmu_arready = 1'b1;
    ifu_araddr = 32'h6000_0000; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
    wait_ar(ok);
    tests_run++;
    if (!ok || ifu_arready !== 1'b1 || mmu_arlen !== 8'd3)
      begin tests_failed++; $display("FAIL burst_ar got ok=%b rdy=%b len=%0d want 1 1 3", ok, ifu_arready, mmu_arlen); end
    lsu_araddr = 32'h0000_7000; lsu_arvalid = 1'b1;
    tick();
    ifu_arvalid = 1'b0;
    beats = 0; fwd = 0; leak = 0;
    for (int i = 0; i < 12 && beats < 4; i++) begin
      mmu_rvalid = i[0];
      mmu_rlast = (beats == 3);
      mmu_rdata = 32'hC000_0000 + 32'(beats);
      #1;
      if (lsu_arready || lsu_rvalid || mmu_arvalid) leak++;
      if (mmu_rvalid) begin
        if (ifu_rvalid && ifu_rdata == 32'hC000_0000 + 32'(beats)) fwd++;
        beats++;
      end
      tick();
    end
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0; ifu_arlen = 8'd0;
    tests_run++;
    if (fwd != 4 || beats != 4)
      begin tests_failed++; $display("FAIL burst_beats got fwd=%0d driven=%0d want 4 4", fwd, beats); end
    tests_run++;
    if (leak != 0) begin tests_failed++; $display("FAIL burst_lsu_waits got %0d leaks want 0", leak); end
    #1;
    tests_run++;
    if (mmu_arvalid !== 1'b0 || lsu_arready !== 1'b0)
      begin tests_failed++; $display("FAIL burst_bubble got ar=%b lsu_rdy=%b want 0 0", mmu_arvalid, lsu_arready); end
    run_read(32'h0000_00D4, ok, addr, own, rd);
    tests_run++;
    if (!ok || own !== 1'b1 || addr !== 32'h0000_7000 || rd !== 32'h0000_00D4)
      begin tests_failed++; $display("FAIL burst_then_lsu got ok=%b lsu=%b a=%h d=%h want 1 1 7000 d4", ok, own, addr, rd); end
  endtask

  task automatic test_reset_mid();
    csr_satp = 32'h1234_5000;
    mmu_awready = 1'b1; mmu_wready = 1'b0;
    lsu_awaddr = 32'h8020_0000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'h3;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    aw_hs_cnt = 0; w_hs_cnt = 0;
    tick();
    tick();
    tests_run++;
    if (mmu_awvalid !== 1'b0 || mmu_wvalid !== 1'b1)
      begin tests_failed++; $display("FAIL rstmid_aw_only got aw=%b w=%b want 0 1", mmu_awvalid, mmu_wvalid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (mmu_awvalid !== 1'b0 || mmu_wvalid !== 1'b0 || mmu_arvalid !== 1'b0 || lsu_awready !== 1'b0 || lsu_wready !== 1'b0)
      begin tests_failed++; $display("FAIL rstmid_idle got aw=%b w=%b ar=%b awr=%b wr=%b want 0", mmu_awvalid, mmu_wvalid, mmu_arvalid, lsu_awready, lsu_wready); end
    tests_run++;
    if (mmu_awsatp !== 32'h0) begin tests_failed++; $display("FAIL rstmid_satp got %h want 0", mmu_awsatp); end
    csr_satp = 32'h0000_5678;
    tick();
    tests_run++;
    if (mmu_awvalid !== 1'b1 || mmu_wvalid !== 1'b1 || mmu_awsatp !== 32'h0000_5678)
      begin tests_failed++; $display("FAIL rstmid_fresh got aw=%b w=%b s=%h want 1 1 5678", mmu_awvalid, mmu_wvalid, mmu_awsatp); end
    mmu_wready = 1'b1;
    #1;
    tests_run++;
    if (lsu_awready !== 1'b1 || lsu_wready !== 1'b1)
      begin tests_failed++; $display("FAIL rstmid_readys got aw=%b w=%b want 1 1", lsu_awready, lsu_wready); end
    tick();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; mmu_awready = 1'b0; mmu_wready = 1'b0;
    mmu_bvalid = 1'b1; mmu_bresp = 2'b00;
    #1;
    tests_run++;
    if (lsu_bvalid !== 1'b1 || mmu_bready !== 1'b1)
      begin tests_failed++; $display("FAIL rstmid_b got bv=%b br=%b want 1 1", lsu_bvalid, mmu_bready); end
    tick();
    mmu_bvalid = 1'b0;
    #1;
    tests_run++;
    if (lsu_bvalid !== 1'b0 || mmu_awvalid !== 1'b0 || aw_hs_cnt != 2 || w_hs_cnt != 1)
      begin tests_failed++; $display("FAIL rstmid_done got bv=%b awv=%b aw=%0d w=%0d want 0 0 2 1", lsu_bvalid, mmu_awvalid, aw_hs_cnt, w_hs_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_satp = 32'h0;
    ifu_araddr = '0; ifu_arsize = 3'd2; ifu_arlen = '0; ifu_arburst = 2'b01; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = '0; lsu_arsize = 3'd2; lsu_arlen = '0; lsu_arburst = 2'b01; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0; lsu_bready = 1'b1;
    mmu_arready = 1'b0; mmu_rdata = '0; mmu_rresp = '0; mmu_rlast = 1'b0; mmu_rvalid = 1'b0;
    mmu_awready = 1'b0; mmu_wready = 1'b0; mmu_bresp = '0; mmu_bvalid = 1'b0;
    test_reset();
    test_ifu_read();
    test_tie();
    test_write_then_read();
    test_satp_hold();
    test_burst();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
